// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage registers: state encoding,
// occupancy codes and the RV32 NOP bundle used as a reset payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // addi x0, x0, 0 in the low word of a stage bundle
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ONE:     return OCC_ONE;
      FULL:    return OCC_FULL;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events; clr wins over inc.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic stage register with optional two-entry skid buffer, stall and flush.
// One-cycle latency; SKID=1 gives a registered in_ready that absorbs one stall cycle.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid;
  logic             w_live;
  logic             w_acc;
  logic             w_drn;
  logic             w_load_m;
  logic             w_load_s;
  logic             w_m_from_s;

  assign w_live    = en & ~flush;
  assign out_valid = (r_state != EMPTY);
  assign w_acc     = in_valid & in_ready & w_live;
  assign w_drn     = out_valid & out_ready & w_live;

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] r_skid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_skid <= RESET_VAL;
        end else if (w_load_s) begin
          r_skid <= in_data;
        end
      end

      assign w_skid   = r_skid;
      // Decoded from state only so in_ready never depends on downstream timing
      assign in_ready = (r_state != FULL);
    end else begin : g_noskid
      assign w_skid   = RESET_VAL;
      assign in_ready = w_live & (~out_valid | out_ready);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_m    = 1'b0;
    w_load_s    = 1'b0;
    w_m_from_s  = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ONE;
            w_load_m    = 1'b1;
          end
        end
        ONE: begin
          if (w_acc && w_drn) begin
            w_load_m = 1'b1;
          end else if (w_acc) begin
            // Only reachable with SKID=1; without it an accept in ONE implies a drain
            w_state_nxt = FULL;
            w_load_s    = 1'b1;
          end else if (w_drn) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_drn) begin
            w_state_nxt = ONE;
            w_m_from_s  = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= RESET_VAL;
    end else if (w_load_m) begin
      r_main <= in_data;
    end else if (w_m_from_s) begin
      r_main <= w_skid;
    end
  end

  assign out_data  = r_main;
  assign occupancy = occ_of(r_state);

  sat_counter #(
    .W(CNT_W)
  ) u_bubble (
    .clk(clk),
    .rst(rst),
    .inc(en & out_ready & ~out_valid & ~flush),
    .clr(cnt_clr),
    .cnt(bubble_cnt)
  );

endmodule
